rv16_boot_ctrl: RTL and testbench

Run controller for the rv16r 16-bit pipelined core. It accepts a program stream from a host over a valid/ready handshake and writes it into instruction memory while holding the core in reset. It then releases reset, detects when the program has halted, and applies a cycle watchdog. It reports busy/done/error status and a cycle count, and sits between the host/testbench and the core.

---
 rtl/rv16_ctrl_pkg.sv | 20 ++
 rtl/rv16_halt_detect.sv | 38 +++
 rtl/rv16_boot_ctrl.sv | 143 ++++++++++++++
 tb/tb_rv16_boot_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16_ctrl_pkg.sv
// Shared types and constants for the rv16r run controller.
package rv16_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVF     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Highest PC the core reaches; it parks here when it runs off the program.
    localparam logic [15:0] PC_SAT = 16'h0fff;

endpackage

// File: rtl/rv16_halt_detect.sv
// Halt detector: flags a halt once core_pc has been stable long enough.
module rv16_halt_detect
    import rv16_ctrl_pkg::*;
#(
    parameter int HALT_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] core_pc,
    output logic        halt
);

    localparam int CW = $clog2(HALT_HOLD);
    localparam logic [CW-1:0] SAME_MAX = CW'(HALT_HOLD - 1);

    logic [15:0]   pc_prev;
    logic [CW-1:0] same_cnt;

    // Previous PC sample; data only, so it carries no reset.
    always_ff @(posedge clk) begin
        pc_prev <= core_pc;
    end

    // Count consecutive cycles with an unchanged PC, saturating at the halt threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            same_cnt <= '0;
        end else if (clear || (core_pc != pc_prev)) begin
            same_cnt <= '0;
        end else if (same_cnt != SAME_MAX) begin
            same_cnt <= same_cnt + 1'b1;
        end
    end

    assign halt = (same_cnt == SAME_MAX);

endmodule

// File: rtl/rv16_boot_ctrl.sv
// Boot/run controller: loads a program into imem, releases the core, watches for halt or timeout.
module rv16_boot_ctrl
    import rv16_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int RST_HOLD   = 2,
    parameter int HALT_HOLD  = 8,
    parameter int MAX_CYCLES = 100000,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    input  logic [15:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_rst,
    input  logic [15:0]       core_pc,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int SW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_AT  = CNT_W'(MAX_CYCLES - 1);

    state_t            state, state_d;
    logic [SW-1:0]     settle_cnt, settle_d;
    logic [ADDR_W:0]   words_d;
    logic [CNT_W-1:0]  cyc_d;
    logic [1:0]        err_d;
    logic              accept;
    logic              halt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rv16_halt_detect #(
        .HALT_HOLD(HALT_HOLD)
    ) u_halt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_RUN),
        .core_pc(core_pc),
        .halt   (halt)
    );

    // The write port is driven straight from the handshake so a word lands in the cycle it is accepted.
    assign load_ready = (state == ST_LOAD);
    assign accept     = load_valid & load_ready;
    assign imem_we    = accept;
    assign imem_addr  = accept ? words_loaded[ADDR_W-1:0] : '0;
    assign imem_wdata = accept ? load_data : '0;

    // Next-state and next-value logic; abort beats start, start beats everything else.
    always_comb begin
        state_d  = state;
        settle_d = '0;
        words_d  = words_loaded;
        cyc_d    = cycle_count;
        err_d    = err_code;
        if (accept) begin
            words_d = words_loaded + 1'b1;
        end
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        words_d = '0;
                        cyc_d   = '0;
                        err_d   = ERR_NONE;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (load_last) begin
                            state_d = ST_SETTLE;
                        end else if (&words_loaded[ADDR_W-1:0]) begin
                            state_d = ST_ERR;
                            err_d   = ERR_OVF;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_d = settle_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cyc_d = sat_inc(cycle_count);
                    if (halt) begin
                        state_d = ST_DONE;
                    end else if (cycle_count == TIMEOUT_AT) begin
                        state_d = ST_ERR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            words_loaded <= '0;
            cycle_count  <= '0;
            err_code     <= ERR_NONE;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_d;
            settle_cnt   <= settle_d;
            words_loaded <= words_d;
            cycle_count  <= cyc_d;
            err_code     <= err_d;
            core_rst     <= !((state_d == ST_RUN) || (state_d == ST_DONE));
            busy         <= (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
            done         <= (state_d == ST_DONE);
            error        <= (state_d == ST_ERR);
        end
    end

endmodule

// File: tb/tb_rv16_boot_ctrl.sv
// Testbench for rv16_boot_ctrl: random programs and PC traces against a window-based reference model.
module tb_rv16_boot_ctrl;
    import rv16_ctrl_pkg::*;

    localparam int ADDR_W     = 3;
    localparam int RST_HOLD   = 2;
    localparam int HALT_HOLD  = 4;
    localparam int MAX_CYCLES = 20;
    localparam int CNT_W      = 16;
    localparam int CAP        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, abort, load_valid, load_last;
    logic [15:0]       load_data, core_pc;
    logic              load_ready, imem_we, core_rst, busy, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;
    logic [CNT_W-1:0]  cycle_count;

    rv16_boot_ctrl #(
        .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD), .HALT_HOLD(HALT_HOLD),
        .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .core_pc(core_pc),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .words_loaded(words_loaded), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [15:0]       wd_q[$];
    bit                pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Record every write the DUT issues
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the run ends at the first RUN cycle whose preceding HALT_HOLD PC samples
    // (the last pre-run sample included) are identical; otherwise at RUN cycle MAX_CYCLES-1.
    task automatic model_run(input logic [15:0] s[$], output int kend, output bit halted);
        logic [15:0] h[$];
        bit eq;
        h.push_back(16'h0);
        kend = MAX_CYCLES - 1;
        halted = 1'b0;
        for (int n = 0; n < MAX_CYCLES; n++) begin
            eq = (h.size() >= HALT_HOLD);
            if (eq) begin
                for (int j = 1; j < HALT_HOLD; j++) begin
                    if (h[h.size()-1-j] != h[h.size()-1]) eq = 1'b0;
                end
            end
            if (eq) begin
                kend = n;
                halted = 1'b1;
                return;
            end
            if (n == MAX_CYCLES - 1) begin
                kend = n;
                return;
            end
            h.push_back(s[n]);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_ready", load_ready, 1);
        check("start_words", words_loaded, 0);
        check("start_count", cycle_count, 0);
        check("start_errcode", err_code, ERR_NONE);
        check("start_core_rst", core_rst, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [15:0] prog[$], input bit last, input int mode,
                           output int acc, output bit ovf);
        int idx = 0;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < prog.size(); i++) begin
            acc++;
            if (last && i == prog.size() - 1) break;
            if (i == CAP - 1) begin
                ovf = 1'b1;
                break;
            end
        end
        wa_q.delete();
        wd_q.delete();
        for (int cyc = 0; cyc < 80 && idx < acc; cyc++) begin
            load_valid = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
            load_data  = prog[idx];
            load_last  = last && (idx == prog.size() - 1);
            @(negedge clk);
            if (load_valid && load_ready) idx++;
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 16'h0;
        check("write_count", wa_q.size(), acc);
        for (int i = 0; i < acc && i < wa_q.size(); i++) begin
            check("write_addr", wa_q[i], i);
            check("write_data", wd_q[i], prog[i]);
        end
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic run_phase(input int kind, input int abort_at, input int words_exp);
        logic [15:0] seq[$];
        logic [15:0] v;
        int kend, got_end, r, t;
        bit halted;
        v = 16'($urandom);
        while (seq.size() < 64) begin
            t = seq.size();
            case (kind)
                0: seq.push_back((16'h0ff8 + t > PC_SAT) ? PC_SAT : 16'(16'h0ff8 + t));
                4: seq.push_back((16'h0ff0 + t > PC_SAT) ? PC_SAT : 16'(16'h0ff0 + t));
                1: seq.push_back(16'(16'h0100 + t));
                default: begin
                    r = (kind == 2) ? $urandom_range(1, HALT_HOLD - 1) : $urandom_range(1, HALT_HOLD + 1);
                    repeat (r) if (seq.size() < 64) seq.push_back(v);
                    v = v + 16'($urandom_range(1, 5));
                end
            endcase
        end
        model_run(seq, kend, halted);
        for (int i = 0; i < RST_HOLD; i++) begin
            core_pc = 16'h0;
            @(negedge clk);
            check("settle_core_rst", core_rst, 1);
            check("settle_busy", busy, 1);
            if (i == 0) check("words_loaded", words_loaded, words_exp);
            @(posedge clk); #1;
        end
        if (abort_at >= 0) begin
            for (int k = 0; k < abort_at; k++) begin
                core_pc = seq[k];
                @(negedge clk);
                check("run_core_rst", core_rst, 0);
                @(posedge clk); #1;
            end
            abort = 1'b1;
            core_pc = seq[abort_at];
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("abort_core_rst", core_rst, 1);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_error", error, 0);
            check("abort_ready", load_ready, 0);
            @(posedge clk); #1;
        end else begin
            got_end = -1;
            for (int k = 0; k < MAX_CYCLES + 4; k++) begin
                core_pc = seq[k];
                @(negedge clk);
                if (k == 0) check("run_core_rst", core_rst, 0);
                if (done || error) begin
                    got_end = k - 1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("run_end_cycle", got_end, kend);
            if (got_end >= 0) begin
                check("end_done", done, halted);
                check("end_error", error, !halted);
                check("end_errcode", err_code, halted ? ERR_NONE : ERR_TIMEOUT);
                check("end_core_rst", core_rst, !halted);
                check("end_count", cycle_count, kend + 1);
                @(posedge clk); #1;
                core_pc = 16'($urandom);
                @(negedge clk);
                check("count_frozen", cycle_count, kend + 1);
                @(posedge clk); #1;
            end
        end
        check("stray_writes", wa_q.size(), 0);
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] prog[$];
        int acc;
        bit ovf;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        load_valid = 1'b1; load_data = 16'hA5A5; load_last = 1'b0; core_pc = 16'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_core_rst", core_rst, 1);
        check("rst_ready", load_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_errcode", err_code, 0);
        check("rst_words", words_loaded, 0);
        check("rst_count", cycle_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_valid = 1'b0;

        // Fixed 3-word program with a gapped valid pattern, PC parks at 0x0fff
        do_start();
        prog = '{16'h1234, 16'h0000, 16'hBEEF};
        do_load(prog, 1'b1, 1, acc, ovf);
        run_phase(0, -1, acc);

        // Random program, PC always advancing -> watchdog
        do_start();
        prog.delete();
        repeat ($urandom_range(1, 6)) prog.push_back(16'($urandom));
        do_load(prog, 1'b1, 2, acc, ovf);
        run_phase(1, -1, acc);

        // Fill the whole memory with no last word -> overflow
        do_start();
        prog.delete();
        repeat (CAP) prog.push_back(16'($urandom));
        do_load(prog, 1'b0, 0, acc, ovf);
        @(negedge clk);
        check("ovf_words", words_loaded, CAP);
        check("ovf_error", error, ovf);
        check("ovf_errcode", err_code, ERR_OVF);
        check("ovf_core_rst", core_rst, 1);
        check("ovf_busy", busy, 0);
        check("ovf_ready", load_ready, 0);
        @(posedge clk); #1;

        // Restart after error; halt and timeout coincide
        do_start();
        prog.delete();
        repeat ($urandom_range(1, 7)) prog.push_back(16'($urandom));
        do_load(prog, 1'b1, 2, acc, ovf);
        run_phase(4, -1, acc);

        // Randomized programs and PC traces with stalls
        repeat (8) begin
            do_start();
            prog.delete();
            repeat ($urandom_range(1, 7)) prog.push_back(16'($urandom));
            do_load(prog, 1'b1, 2, acc, ovf);
            run_phase(($urandom_range(0, 1) != 0) ? 2 : 3, -1, acc);
        end

        // Abort in the middle of a run
        do_start();
        prog.delete();
        repeat (2) prog.push_back(16'($urandom));
        do_load(prog, 1'b1, 0, acc, ovf);
        run_phase(1, 3, acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
